snow64_bfloat16_vec_add_seq: RTL and testbench

SNOW64_BFLOAT16_VEC_ADD_SEQ -- requirements
Module: snow64_bfloat16_vec_add_seq

---
 rtl/snow64_bfloat16_vec_add_seq_pkg.sv | 35 +++
 rtl/snow64_bfloat16_vec_add_seq.sv | 85 ++++++++
 tb/tb_snow64_bfloat16_vec_add_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/snow64_bfloat16_vec_add_seq_pkg.sv
// snow64_bfloat16_vec_add_seq_pkg: lane constants, FSM/port types and lane-insert helper for the vector add sequencer
package snow64_bfloat16_vec_add_seq_pkg;
  localparam int NUM_LANES = 4;
  localparam int WIDTH__BF16 = 16;
  localparam int WIDTH__VEC = 64;
  typedef enum logic [1:0] {StVIdle, StVIssue, StVWait, StVDone} state_vec_add_seq_t;
  typedef struct packed {
    logic start;
    logic [WIDTH__VEC-1:0] a;
    logic [WIDTH__VEC-1:0] b;
  } port_in_vec_add_seq_t;
  typedef struct packed {
    logic can_accept_cmd;
    logic data_valid;
    logic [WIDTH__VEC-1:0] data;
  } port_out_vec_add_seq_t;
  typedef struct packed {
    logic start;
    logic [WIDTH__BF16-1:0] a;
    logic [WIDTH__BF16-1:0] b;
  } port_in_add_t;
  typedef struct packed {
    logic can_accept_cmd;
    logic data_valid;
    logic [WIDTH__BF16-1:0] data;
  } port_out_add_t;
  function automatic logic [WIDTH__VEC-1:0] set_lane(input logic [WIDTH__VEC-1:0] v,
                                                     input logic [1:0] idx,
                                                     input logic [WIDTH__BF16-1:0] val);
    logic [WIDTH__VEC-1:0] r;
    r = v;
    r[WIDTH__BF16*idx +: WIDTH__BF16] = val;
    return r;
  endfunction
endpackage

// File: rtl/snow64_bfloat16_vec_add_seq.sv
// snow64_bfloat16_vec_add_seq: feeds 4 BFloat16 lanes one at a time through an external scalar adder.
// Optional SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN adds in_mask; masked-off lanes pass in_a through.
module snow64_bfloat16_vec_add_seq
  import snow64_bfloat16_vec_add_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_start,
  input  logic [WIDTH__VEC-1:0]  in_a,
  input  logic [WIDTH__VEC-1:0]  in_b,
`ifdef SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN
  input  logic [NUM_LANES-1:0]   in_mask,
`endif
  output logic                   out_can_accept_cmd,
  output logic                   out_data_valid,
  output logic [WIDTH__VEC-1:0]  out_data,
  output logic                   out_add_start,
  output logic [WIDTH__BF16-1:0] out_add_a,
  output logic [WIDTH__BF16-1:0] out_add_b,
  input  logic                   in_add_can_accept_cmd,
  input  logic                   in_add_data_valid,
  input  logic [WIDTH__BF16-1:0] in_add_data
);
  localparam logic [1:0] ST_V_IDLE = StVIdle;
  localparam logic [1:0] ST_V_ISSUE = StVIssue;
  localparam logic [1:0] ST_V_WAIT = StVWait;
  localparam logic [1:0] ST_V_DONE = StVDone;
  localparam logic [1:0] LAST_LANE = 2'(NUM_LANES - 1);
  logic [1:0] state, cnt;
  logic [WIDTH__VEC-1:0] a_q, b_q, work, data_q;
  logic bypass;
`ifdef SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN
  logic [NUM_LANES-1:0] mask_q;
  assign bypass = !mask_q[cnt];
`else
  assign bypass = 1'b0;
`endif
  assign out_can_accept_cmd = state == ST_V_IDLE;
  assign out_data_valid = state == ST_V_DONE;
  assign out_data = data_q;
  assign out_add_a = a_q[WIDTH__BF16*cnt +: WIDTH__BF16];
  assign out_add_b = b_q[WIDTH__BF16*cnt +: WIDTH__BF16];
  assign out_add_start = state == ST_V_ISSUE && !bypass && in_add_can_accept_cmd;
  // out_data is loaded as the last lane lands so it only changes alongside the valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_V_IDLE;
      cnt <= 2'd0;
      a_q <= '0;
      b_q <= '0;
      work <= '0;
      data_q <= '0;
`ifdef SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      case (state)
        ST_V_IDLE: if (in_start) begin
          a_q <= in_a;
          b_q <= in_b;
`ifdef SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN
          mask_q <= in_mask;
`endif
          cnt <= 2'd0;
          state <= ST_V_ISSUE;
        end
        ST_V_ISSUE: if (bypass) begin
          work <= set_lane(work, cnt, out_add_a);
          if (cnt == LAST_LANE) data_q <= set_lane(work, cnt, out_add_a);
          cnt <= cnt == LAST_LANE ? cnt : cnt + 2'd1;
          state <= cnt == LAST_LANE ? ST_V_DONE : ST_V_ISSUE;
        end else if (in_add_can_accept_cmd) begin
          state <= ST_V_WAIT;
        end
        ST_V_WAIT: if (in_add_data_valid) begin
          work <= set_lane(work, cnt, in_add_data);
          if (cnt == LAST_LANE) data_q <= set_lane(work, cnt, in_add_data);
          cnt <= cnt == LAST_LANE ? cnt : cnt + 2'd1;
          state <= cnt == LAST_LANE ? ST_V_DONE : ST_V_ISSUE;
        end
        default: state <= ST_V_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snow64_bfloat16_vec_add_seq.sv
// tb_snow64_bfloat16_vec_add_seq: directed checks of the vector add sequencer against a 3-cycle model adder
module tb_snow64_bfloat16_vec_add_seq;
  logic clk = 0, rst = 1, in_start = 0;
  logic [63:0] in_a = '0, in_b = '0;
  logic in_add_can_accept_cmd = 1;
  logic in_add_data_valid;
  logic [15:0] in_add_data;
`ifdef SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN
  logic [3:0] in_mask = 4'hF;
`endif
  logic out_can_accept_cmd, out_data_valid, out_add_start;
  logic [63:0] out_data;
  logic [15:0] out_add_a, out_add_b;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_add = 0, n_valid = 0, v_cyc = -1, n_acc = 0, acc_cyc = -1;
  localparam logic [63:0] A1 = 64'h3F80_4000_3F00_3F80;
  localparam logic [63:0] B1 = 64'h3F80_3F80_3F00_3F80;
  localparam logic [63:0] R1 = 64'h4000_4040_3F80_4000;

  snow64_bfloat16_vec_add_seq dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_a(in_a), .in_b(in_b),
`ifdef SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN
    .in_mask(in_mask),
`endif
    .out_can_accept_cmd(out_can_accept_cmd), .out_data_valid(out_data_valid), .out_data(out_data),
    .out_add_start(out_add_start), .out_add_a(out_add_a), .out_add_b(out_add_b),
    .in_add_can_accept_cmd(in_add_can_accept_cmd), .in_add_data_valid(in_add_data_valid),
    .in_add_data(in_add_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3F80_3F80: return 16'h4000;
      32'h4000_3F80: return 16'h4040;
      32'h3F00_3F00: return 16'h3F80;
      32'h3F80_BF80: return 16'h0000;
      default:       return 16'hDEAD;
    endcase
  endfunction

  logic [2:0] pv = '0;
  logic [15:0] pd0 = '0, pd1 = '0, pd2 = '0;
  always @(posedge clk) begin
    pv <= {pv[1:0], out_add_start};
    pd0 <= bf_add(out_add_a, out_add_b);
    pd1 <= pd0;
    pd2 <= pd1;
  end
  assign in_add_data_valid = pv[2];
  assign in_add_data = pd2;

  always @(negedge clk) begin
    if (out_add_start) n_add++;
    if (out_data_valid) begin n_valid++; v_cyc = cyc; end
    if (in_start && out_can_accept_cmd) begin n_acc++; acc_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int prev, input int max_cyc);
    int k = 0;
    while (n_valid == prev && k < max_cyc) begin tick(1); k++; end
    if (n_valid == prev) check("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int s, na, nv, nc;
    tick(2);
    @(negedge clk);
    check("rst_accept", 64'(out_can_accept_cmd), 64'd1);
    check("rst_valid", 64'(out_data_valid), 64'd0);
    check("rst_add_start", 64'(out_add_start), 64'd0);
    check("rst_data", out_data, 64'd0);
    tick(1);
    rst = 0;
    // basic command with an ignored start while busy
    na = n_add; nv = n_valid; nc = n_acc; s = cyc;
    in_a = A1; in_b = B1; in_start = 1;
    tick(1);
    in_start = 0;
    tick(2);
    in_a = '1; in_start = 1;
    check("busy_accept", 64'(out_can_accept_cmd), 64'd0);
    tick(1);
    in_start = 0;
    wait_valid(nv, 40);
    check("lat_basic", 64'(v_cyc - s), 64'd17);
    check("data_basic", out_data, R1);
    check("adds_basic", 64'(n_add - na), 64'd4);
    check("accepts_basic", 64'(n_acc - nc), 64'd1);
    check("valid_one_cycle", 64'(out_data_valid), 64'd0);
    tick(3);
    check("valid_count", 64'(n_valid - nv), 64'd1);
    check("data_hold", out_data, R1);
    // adder backpressure during lane 2 issue
    na = n_add; nv = n_valid; s = cyc;
    in_a = A1; in_start = 1;
    tick(1);
    in_start = 0;
    tick(8);
    check("stall_lane_a", 64'(out_add_a), 64'h4000);
    check("stall_lane_b", 64'(out_add_b), 64'h3F80);
    in_add_can_accept_cmd = 0;
    nc = n_add;
    tick(5);
    check("stall_adds", 64'(n_add - nc), 64'd0);
    in_add_can_accept_cmd = 1;
    wait_valid(nv, 40);
    check("lat_stall", 64'(v_cyc - s), 64'd22);
    check("data_stall", out_data, R1);
    check("adds_stall", 64'(n_add - na), 64'd4);
    // reset in lane 1 wait, late adder response must be dropped
    s = cyc;
    in_start = 1;
    tick(1);
    in_start = 0;
    tick(5);
    rst = 1;
    tick(1);
    rst = 0;
    nv = n_valid;
    tick(6);
    check("abort_no_valid", 64'(n_valid - nv), 64'd0);
    check("abort_data", out_data, 64'd0);
    check("abort_accept", 64'(out_can_accept_cmd), 64'd1);
    na = n_add; s = cyc;
    in_a = {4{16'h3F80}}; in_b = {4{16'hBF80}}; in_start = 1;
    tick(1);
    in_start = 0;
    wait_valid(nv, 40);
    check("lat_zero", 64'(v_cyc - s), 64'd17);
    check("data_zero", out_data, 64'd0);
    check("adds_zero", 64'(n_add - na), 64'd4);
    // start held across done: re-accepted only once idle
    tick(2);
    nv = n_valid; nc = n_acc; s = cyc;
    in_a = A1; in_b = B1; in_start = 1;
    wait_valid(nv, 40);
    check("held_lat1", 64'(v_cyc - s), 64'd17);
    check("held_acc_before_idle", 64'(n_acc - nc), 64'd1);
    tick(1);
    in_start = 0;
    check("held_acc_idle", 64'(n_acc - nc), 64'd2);
    check("held_acc_cyc", 64'(acc_cyc - s), 64'd18);
    wait_valid(nv + 1, 40);
    check("held_lat2", 64'(v_cyc - s), 64'd35);
    check("held_data", out_data, R1);
    tick(3);
    check("held_acc_total", 64'(n_acc - nc), 64'd2);
`ifdef SNOW64_BFLOAT16_VEC_ADD_SEQ_LANE_MASK_EN
    na = n_add; nv = n_valid; s = cyc;
    in_mask = 4'b0101; in_start = 1;
    tick(1);
    in_start = 0;
    in_mask = 4'hF;
    wait_valid(nv, 40);
    check("mask_lat", 64'(v_cyc - s), 64'd11);
    check("mask_adds", 64'(n_add - na), 64'd2);
    check("mask_data", out_data, 64'h3F80_4040_3F00_4000);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
